// File: rtl/cr_structs_pkg.sv
// rtl/cr_structs_pkg.sv - shared AXI4-Stream datapath bus and ready types
package cr_structs;

  typedef struct packed {
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tid;
    logic [3:0]  tstrb;
    logic [3:0]  tuser;
    logic        tlast;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

endpackage

// File: rtl/nx_ib_interface_monitor_pipe_pkg.sv
// rtl/nx_ib_interface_monitor_pipe_pkg.sv - nx buffer-state enum and next-state helper
package nx_ib_interface_monitor_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } nx_buf_state_e;

  function automatic nx_buf_state_e nx_buf_next(input nx_buf_state_e state,
                                                input logic accept,
                                                input logic deliver);
    nx_buf_state_e nxt;
    nxt = state;
    case (state)
      EMPTY: if (accept) nxt = ONE;
      ONE: begin
        if (accept && !deliver)      nxt = FULL;
        else if (deliver && !accept) nxt = EMPTY;
      end
      FULL:    if (deliver) nxt = ONE;
      default: nxt = EMPTY;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/nx_ib_interface_monitor_pipe_frame_cnt.sv
// rtl/nx_ib_interface_monitor_pipe_frame_cnt.sv - per-frame delivered-beat counter with length error pulse
module nx_ib_mon_frame_cnt #(
  parameter logic [15:0] MAX_BEATS = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        deliver,
  input  logic        tlast,
  output logic [15:0] beat_cnt,
  output logic        frame_err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= 16'd0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (deliver) begin
        if (tlast) begin
          beat_cnt <= 16'd0;
        end else if (beat_cnt < MAX_BEATS) begin
          // Error fires once, on the beat that reaches the limit; later beats just saturate.
          beat_cnt  <= beat_cnt + 16'd1;
          frame_err <= ((beat_cnt + 16'd1) == MAX_BEATS);
        end
      end
    end
  end

endmodule

// File: rtl/nx_ib_interface_monitor_pipe.sv
// rtl/nx_ib_interface_monitor_pipe.sv - ingress skid buffer gated by monitor ready; frame check under NX_IB_MON_FRAME_CHECK_EN
module nx_ib_interface_monitor_pipe
  import cr_structs::*;
  import nx_ib_interface_monitor_pipe_pkg::*;
#(
  parameter logic [15:0] MAX_BEATS = 16'd4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  axi4s_dp_bus_t ib_in,
  output axi4s_dp_rdy_t ib_out,
  output axi4s_dp_bus_t ib_in_mod,
  input  axi4s_dp_rdy_t ib_out_core,
  input  logic          im_rdy,
  output logic          im_vld,
  output logic          frame_err,
  output logic [15:0]   beat_cnt
);

  nx_buf_state_e state;
  axi4s_dp_bus_t main_q;
  axi4s_dp_bus_t skid_q;
  logic          tready_q;
  logic          accept;
  logic          deliver;

  assign ib_out.tready = tready_q;
  assign accept        = ib_in.tvalid & tready_q;
  assign deliver       = ib_in_mod.tvalid & ib_out_core.tready;
  assign im_vld        = deliver;

  // Payload always comes from the main register; only tvalid sees im_rdy.
  always_comb begin
    ib_in_mod        = main_q;
    ib_in_mod.tvalid = (state != EMPTY) & im_rdy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      tready_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      state    <= nx_buf_next(state, accept, deliver);
      tready_q <= (nx_buf_next(state, accept, deliver) != FULL);
      case (state)
        EMPTY: if (accept) main_q <= ib_in;
        ONE: begin
          if (accept && deliver) main_q <= ib_in;
          else if (accept)       skid_q <= ib_in;
        end
        FULL:    if (deliver) main_q <= skid_q;
        default: ;
      endcase
    end
  end

`ifdef NX_IB_MON_FRAME_CHECK_EN
  nx_ib_mon_frame_cnt #(
    .MAX_BEATS (MAX_BEATS)
  ) u_frame_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .deliver   (deliver),
    .tlast     (ib_in_mod.tlast),
    .beat_cnt  (beat_cnt),
    .frame_err (frame_err)
  );
`else
  assign beat_cnt  = 16'd0;
  assign frame_err = 1'b0;
`endif

endmodule
